mux_sel_pipe: RTL and testbench

Parametrised N-to-1 word multiplexer with a registered output stage and a valid/ready handshake, for datapath selection points that need a pipeline break. It has two modes. In direct mode the channel is chosen by a select bus. In scan mode it walks round-robin over a channel enable mask. It is the generalised, sequential successor to the fixed 8-input combinational word mux and sits between datapath producers and a registered consumer (e.g. writeback or debug capture).

---
 rtl/mux_sel_pipe_if.sv | 52 +++++
 rtl/mux_sel_pipe.sv | 148 ++++++++++++++
 tb/tb_mux_sel_pipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_pipe_if.sv
// mux_sel_pipe_if
// ----------------
// Bundles the capture handshake, the selection controls and the registered
// output handshake of mux_sel_pipe. The clock and reset stay outside.
//
// Modports:
//   slave  : the multiplexer side. It receives the data, selection and
//            consumer-ready signals and drives in_ready, out_data, out_sel,
//            out_valid and sel_err.
//   master : the producer/consumer side, which is the mirror image.
//
// Signals:
//   in_data   NUM_IN*WIDTH  channel k sits at [k*WIDTH +: WIDTH]
//   in_valid  1             capture request
//   in_ready  1             capture accepted this cycle when in_valid=1
//   mode      1             0 = direct select, 1 = round-robin scan
//   sel       SEL_W         channel index in direct mode
//   scan_mask NUM_IN        channel enable mask in scan mode
//   scan_clr  1             synchronous clear of the scan pointer
//   out_data  WIDTH         registered selected word
//   out_sel   SEL_W         index of the captured channel
//   out_valid 1             out_data holds an unconsumed word
//   out_ready 1             consumer accepts out_data
//   sel_err   1             last capture attempt had no valid target
interface mux_sel_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN-1:0]       scan_mask;
    logic                    scan_clr;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;

    modport slave (
        input  in_data, in_valid, mode, sel, scan_mask, scan_clr, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err
    );

    modport master (
        output in_data, in_valid, mode, sel, scan_mask, scan_clr, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err
    );
endinterface

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe
// ------------
// N-to-1 word multiplexer with a registered output stage and a valid/ready
// handshake on both sides. In direct mode the channel comes from sel. In scan
// mode the block walks round-robin over the channels enabled in scan_mask.
// It starts each search at a stored pointer and wraps around.
//
// Ports:
//   Clk    input   rising-edge clock
//   Reset  input   asynchronous, active-high reset
//   bus    slave modport of mux_sel_pipe_if (see the interface for the list)
//
// Timing:
//   A word is captured (fire) when in_valid, in_ready and a valid target all
//   hold. It appears on out_data one edge later. in_ready is combinational,
//   equal to !out_valid || out_ready, so a full stage can pass one word per
//   cycle while the consumer keeps out_ready high.
module mux_sel_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    mux_sel_pipe_if.slave bus
);

    // Registered state
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_sel_r;
    logic             out_valid_r;
    logic             sel_err_r;
    logic [SEL_W-1:0] ptr_r;

    // Combinational decode
    logic             scan_hit_s;
    logic [SEL_W-1:0] scan_idx_s;
    logic [SEL_W-1:0] target_s;
    logic             target_ok_s;
    logic [WIDTH-1:0] sel_word_s;
    logic             in_ready_s;
    logic             fire_s;
    logic             bad_attempt_s;
    logic [SEL_W-1:0] ptr_next_s;

    // Round-robin search. The first pass covers ptr..NUM_IN-1 and the second
    // pass covers 0..ptr-1, so the lowest index at or after ptr wins.
    always_comb begin
        scan_hit_s = 1'b0;
        scan_idx_s = {SEL_W{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            if (!scan_hit_s && bus.scan_mask[k] && (k >= int'(ptr_r))) begin
                scan_hit_s = 1'b1;
                scan_idx_s = SEL_W'(k);
            end else begin
                scan_hit_s = scan_hit_s;
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (!scan_hit_s && bus.scan_mask[k] && (k < int'(ptr_r))) begin
                scan_hit_s = 1'b1;
                scan_idx_s = SEL_W'(k);
            end else begin
                scan_hit_s = scan_hit_s;
            end
        end
    end

    // Pick the target channel and decide whether it can be captured
    always_comb begin
        if (bus.mode) begin
            target_s    = scan_idx_s;
            target_ok_s = scan_hit_s;
        end else begin
            target_s    = bus.sel;
            // sel can encode indices beyond NUM_IN when NUM_IN is not a power of 2
            target_ok_s = (int'(bus.sel) < NUM_IN);
        end
    end

    // Word mux. Only constant part-selects are used, and an out-of-range
    // target yields zero.
    always_comb begin
        sel_word_s = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(target_s) == k) begin
                sel_word_s = bus.in_data[k*WIDTH +: WIDTH];
            end else begin
                sel_word_s = sel_word_s;
            end
        end
    end

    // Handshake qualifiers and the next scan pointer
    always_comb begin
        in_ready_s    = !out_valid_r || bus.out_ready;
        fire_s        = bus.in_valid && in_ready_s && target_ok_s;
        bad_attempt_s = bus.in_valid && in_ready_s && !target_ok_s;
        // The wrap uses an explicit compare, so a non-power-of-2 NUM_IN
        // never lets the pointer reach an unused index.
        if (int'(scan_idx_s) == (NUM_IN - 1)) begin
            ptr_next_s = {SEL_W{1'b0}};
        end else begin
            ptr_next_s = scan_idx_s + SEL_W'(1'b1);
        end
    end

    // Output stage: capture on fire, otherwise drain on consume and track errors
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            sel_err_r   <= 1'b0;
        end else if (fire_s) begin
            out_data_r  <= sel_word_s;
            out_sel_r   <= target_s;
            out_valid_r <= 1'b1;
            sel_err_r   <= 1'b0;
        end else begin
            if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (bad_attempt_s) begin
                sel_err_r <= 1'b1;
            end
        end
    end

    // Scan pointer. A clear beats a same-cycle advance, but the search for
    // that fire has already used the old pointer.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_r <= {SEL_W{1'b0}};
        end else if (bus.scan_clr) begin
            ptr_r <= {SEL_W{1'b0}};
        end else if (fire_s && bus.mode) begin
            ptr_r <= ptr_next_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sel_err   = sel_err_r;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe. Instance A has 8 channels and instance B
// has 6 channels, which leaves sel encodings that are out of range.
// Each expected capture goes into a scoreboard queue when its stimulus is
// driven. It is popped and compared after the capturing edge.
module tb_mux_sel_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_sel_pipe_if #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) ifa ();
    mux_sel_pipe_if #(.WIDTH(32), .NUM_IN(6), .SEL_W(3)) ifb ();

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) dut_a (
        .Clk   (clk),
        .Reset (rst),
        .bus   (ifa.slave)
    );

    mux_sel_pipe #(.WIDTH(32), .NUM_IN(6), .SEL_W(3)) dut_b (
        .Clk   (clk),
        .Reset (rst),
        .bus   (ifb.slave)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  sel;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   errors = 0;
    int   checks = 0;
    int   scan_seq [5] = '{1, 4, 7, 1, 4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int ch);
        exp_t e;
        e.data = 32'h1000_0000 + ch;
        e.sel  = ch[2:0];
        sb_a.push_back(e);
    endtask

    task automatic push_b(input int ch);
        exp_t e;
        e.data = 32'h2000_0000 + ch;
        e.sel  = ch[2:0];
        sb_b.push_back(e);
    endtask

    task automatic pop_a(input string tag);
        exp_t e;
        if (sb_a.size() != 0) begin
            e = sb_a.pop_front();
            chk({tag, "_data"}, ifa.out_data, e.data);
            chk({tag, "_sel"}, 32'(ifa.out_sel), 32'(e.sel));
            chk({tag, "_valid"}, 32'(ifa.out_valid), 32'd1);
        end else begin
            chk({tag, "_sb_a_empty"}, 32'(sb_a.size()), 32'd1);
        end
    endtask

    task automatic pop_b(input string tag);
        exp_t e;
        if (sb_b.size() != 0) begin
            e = sb_b.pop_front();
            chk({tag, "_data"}, ifb.out_data, e.data);
            chk({tag, "_sel"}, 32'(ifb.out_sel), 32'(e.sel));
            chk({tag, "_valid"}, 32'(ifb.out_valid), 32'd1);
        end else begin
            chk({tag, "_sb_b_empty"}, 32'(sb_b.size()), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 8; k++) ifa.in_data[k*32 +: 32] = 32'h1000_0000 + k;
        for (int k = 0; k < 6; k++) ifb.in_data[k*32 +: 32] = 32'h2000_0000 + k;
        ifa.in_valid = 1'b0; ifa.mode = 1'b0; ifa.sel = 3'd0;
        ifa.scan_mask = 8'd0; ifa.scan_clr = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.mode = 1'b0; ifb.sel = 3'd0;
        ifb.scan_mask = 6'd0; ifb.scan_clr = 1'b0; ifb.out_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_out_data", ifa.out_data, 32'h0);
        chk("rst_out_sel", 32'(ifa.out_sel), 32'd0);
        chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_sel_err", 32'(ifa.sel_err), 32'd0);
        chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
        chk("rst_b_out_valid", 32'(ifb.out_valid), 32'd0);
        rst = 1'b0;

        // Basic direct capture
        ifa.sel = 3'd5; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
        push_a(5); tick(); pop_a("direct5");
        ifa.in_valid = 1'b0;

        // Asynchronous reset mid-cycle drops the held word at once
        #2; rst = 1'b1; #1;
        chk("async_rst_valid", 32'(ifa.out_valid), 32'd0);
        chk("async_rst_data", ifa.out_data, 32'h0);
        chk("async_rst_sel", 32'(ifa.out_sel), 32'd0);
        #1; rst = 1'b0;

        // Backpressure
        ifa.sel = 3'd5; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
        push_a(5); tick(); pop_a("bp_load5");
        ifa.sel = 3'd2; ifa.out_ready = 1'b0; #1;
        chk("bp_in_ready_low", 32'(ifa.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", ifa.out_data, 32'h1000_0005);
            chk("bp_hold_sel", 32'(ifa.out_sel), 32'd5);
            chk("bp_hold_in_ready", 32'(ifa.in_ready), 32'd0);
        end
        ifa.out_ready = 1'b1;
        push_a(2); tick(); pop_a("bp_release2");
        ifa.in_valid = 1'b0; tick();
        chk("consume_valid", 32'(ifa.out_valid), 32'd0);

        // Scan wrap, one word per cycle
        ifa.mode = 1'b1; ifa.scan_mask = 8'b1001_0010; ifa.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_a(scan_seq[i]); tick(); pop_a("scan_wrap");
        end

        // Mask change with ptr=5, then scan_clr together with a fire
        ifa.scan_mask = 8'b0000_0101;
        push_a(0); tick(); pop_a("mask_ch0");
        ifa.scan_clr = 1'b1;
        push_a(2); tick(); pop_a("clr_fire2");
        ifa.scan_clr = 1'b0;
        push_a(0); tick(); pop_a("after_clr0");
        // This mask makes the cleared pointer (0) distinguishable from 3
        ifa.scan_mask = 8'b0000_1101; ifa.scan_clr = 1'b1;
        push_a(2); tick(); pop_a("clr2_fire2");
        ifa.scan_clr = 1'b0;
        push_a(0); tick(); pop_a("clr2_after0");

        // Mode switching leaves ptr (now 1) alone
        ifa.mode = 1'b0; ifa.sel = 3'd6;
        push_a(6); tick(); pop_a("switch_direct6");
        ifa.mode = 1'b1;
        push_a(2); tick(); pop_a("resume_scan2");

        // Empty mask: no capture, the word drains, and the error is sticky
        ifa.scan_mask = 8'd0; tick();
        chk("empty_sel_err", 32'(ifa.sel_err), 32'd1);
        chk("empty_valid", 32'(ifa.out_valid), 32'd0);
        chk("empty_data_kept", ifa.out_data, 32'h1000_0002);
        chk("empty_sel_kept", 32'(ifa.out_sel), 32'd2);
        tick();
        chk("empty_sel_err_sticky", 32'(ifa.sel_err), 32'd1);
        ifa.scan_mask = 8'b0000_1000;
        push_a(3); tick(); pop_a("mask_restore3");
        chk("restore_sel_err", 32'(ifa.sel_err), 32'd0);
        // ptr is 4 here. An empty-mask cycle must not move it.
        ifa.scan_mask = 8'd0; tick();
        ifa.scan_mask = 8'b0001_0001;
        push_a(4); tick(); pop_a("ptr_kept4");
        ifa.in_valid = 1'b0; tick();

        // Out-of-range direct select on the 6-channel instance
        ifb.out_ready = 1'b1; ifb.sel = 3'd7; ifb.in_valid = 1'b1; tick();
        chk("b_oor7_err", 32'(ifb.sel_err), 32'd1);
        chk("b_oor7_valid", 32'(ifb.out_valid), 32'd0);
        chk("b_oor7_in_ready", 32'(ifb.in_ready), 32'd1);
        ifb.sel = 3'd6; tick();
        chk("b_oor6_err", 32'(ifb.sel_err), 32'd1);
        chk("b_oor6_valid", 32'(ifb.out_valid), 32'd0);
        ifb.sel = 3'd1;
        push_b(1); tick(); pop_b("b_sel1");
        chk("b_sel1_err_clr", 32'(ifb.sel_err), 32'd0);
        ifb.sel = 3'd5;
        push_b(5); tick(); pop_b("b_sel5");
        ifb.sel = 3'd7; tick();
        chk("b_oor_after_err", 32'(ifb.sel_err), 32'd1);
        chk("b_oor_after_data", ifb.out_data, 32'h2000_0005);
        chk("b_oor_after_sel", 32'(ifb.out_sel), 32'd5);
        ifb.in_valid = 1'b0; tick();

        chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
        chk("sb_b_drained", 32'(sb_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
